gb_savestate_scheduler: RTL
===========================

GB_SAVESTATE_SCHEDULER -- requirements
Module: gb_savestate_scheduler

Interface
REQ-001 SHALL have parameter SLOT_BASE, default 32'h0200_0000, byte base of the four manual savestate slots.
REQ-002 SHALL have parameter SLOT_SIZE, default 32'h0010_0000, byte stride between consecutive slots (manual and rewind).
REQ-003 SHALL have parameter REWIND_BASE, default 32'h0240_0000, byte base of the rewind ring.
REQ-004 SHALL have parameter REWIND_DEPTH, default 16, number of rewind ring entries, range 2..256.
REQ-005 SHALL have parameter REWIND_INTERVAL, default 60, vsync edges between rewind captures, range 1..255.
REQ-006 SHALL have parameter SETTLE_CYCLES, default 4, core_sleep cycles before the request pulse, range 1..15.
REQ-007 SHALL have parameter ACK_TIMEOUT, default 255, cycles allowed for request_busy to rise, range 1..255.
REQ-008 SHALL have ports: clk  in  1  system clock; one clock; reset is synchronous and active-low.
REQ-009 SHALL have ports: reset_n  in  1  synchronous active-low reset.
REQ-010 SHALL have ports: save  in  1  manual save pulse; load  in  1  manual load pulse; slot  in  2  manual slot index.
REQ-011 SHALL have ports: rewind_on  in  1  rewind hold level; vsync  in  1  core vsync level.
REQ-012 SHALL have ports: request_savestate  out  1; request_loadstate  out  1; request_address  out  32; request_busy  in  1  memory engine busy.
REQ-013 SHALL have ports: core_sleep  out  1  core halt; busy  out  1  state machine not in IDLE; rewind_active  out  1; timeout_err  out  1  sticky error.

Function
REQ-014 SHALL implement states IDLE, WAIT_VS, SLEEP, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-015 SHALL detect the vsync rising edge as vsync=1 with the registered previous vsync=0.
REQ-016 SHALL accept requests only in IDLE; save/load arriving in any other state are dropped.
REQ-017 SHALL give priority, in IDLE, to manual save, then manual load, then rewind load, then rewind capture; a manual request and a rewind event in the same cycle resolve to the manual request.
REQ-018 SHALL latch the operation and address on acceptance, then go to WAIT_VS.
REQ-019 SHALL compute the manual address as SLOT_BASE + slot*SLOT_SIZE and the ring address as REWIND_BASE + idx*SLOT_SIZE, both modulo 2^32.
REQ-020 SHALL leave WAIT_VS for SLEEP on the vsync edge; core_sleep is high from the first SLEEP cycle through the last WAIT_DONE cycle.
REQ-021 SHALL hold SLEEP for exactly SETTLE_CYCLES cycles, then spend one cycle in ISSUE.
REQ-022 SHALL, in ISSUE, pulse exactly one of request_savestate/request_loadstate for one cycle, with request_address valid in that cycle.
REQ-023 SHALL, in WAIT_ACK, go to WAIT_DONE when request_busy=1, or to IDLE and set timeout_err once ACK_TIMEOUT cycles elapse.
REQ-024 SHALL, in WAIT_DONE, return to IDLE in the cycle after request_busy=0.
REQ-025 SHALL clear timeout_err when the next request is accepted.
REQ-026 SHALL hold request_address at 0 except during ISSUE.
REQ-027 SHALL set the rewind valid count to 0 on completion of a manual load.

Reset
REQ-028 SHALL, on reset_n=0 at a clk edge (including mid-operation): enter IDLE; drive all outputs 0; clear the vsync edge register, ring write index, valid count and interval counter.

Configuration
REQ-029 SHALL compile the rewind ring only when GB_SS_REWIND_EN is defined.
REQ-030 SHALL, when GB_SS_REWIND_EN is defined: count vsync edges while rewind_on=0.
REQ-031 SHALL, on reaching REWIND_INTERVAL (GB_SS_REWIND_EN defined), schedule a save to ring[wr_idx]; on its completion increment wr_idx (wrap DEPTH-1 to 0) and increment valid, saturating at DEPTH.
REQ-032 SHALL, when GB_SS_REWIND_EN is defined and rewind_on=1 with valid>0, schedule a load on each vsync edge from ring[wr_idx-1] (wrapping 0 to DEPTH-1); on completion decrement wr_idx and valid.
REQ-033 SHALL drive rewind_active = rewind_on AND valid!=0 when GB_SS_REWIND_EN is defined.
REQ-034 SHALL, without GB_SS_REWIND_EN: ignore rewind_on, tie rewind_active to 0, perform no periodic captures, and leave the REWIND_* parameters unused.

Verification
REQ-035 SHALL cover: save=1, slot=2, then vsync edge, busy 3 cycles -> request_savestate pulses 5 cycles after the edge, address 32'h0220_0000, core_sleep low after busy falls.
REQ-036 SHALL cover: save and load in the same cycle, slot=1 -> only request_savestate pulses, address 32'h0210_0000; a load issued during WAIT_VS is dropped.
REQ-037 SHALL cover: request_busy never rises -> timeout_err=1 after 255 WAIT_ACK cycles, IDLE, core_sleep=0; next save clears timeout_err.
REQ-038 SHALL cover (GB_SS_REWIND_EN): 17 captures with DEPTH=16 -> wr_idx wraps to 1, valid=16; rewind_on loads from idx 0, then 15.
REQ-039 SHALL cover: reset_n=0 during SLEEP -> next cycle all outputs 0, busy=0; a subsequent save completes normally.

Source files
------------

// File: rtl/gb_savestate_scheduler.sv
// Savestate scheduler: arbitrates manual save/load and the optional rewind ring, then parks the core at vsync and issues one request.
// Optional rewind ring enabled by defining GB_SS_REWIND_EN.
module gb_savestate_scheduler #(
    parameter logic [31:0] SLOT_BASE       = 32'h0200_0000,
    parameter logic [31:0] SLOT_SIZE       = 32'h0010_0000,
    parameter logic [31:0] REWIND_BASE     = 32'h0240_0000,
    parameter int          REWIND_DEPTH    = 16,
    parameter int          REWIND_INTERVAL = 60,
    parameter int          SETTLE_CYCLES   = 4,
    parameter int          ACK_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        save_i,
    input  logic        load_i,
    input  logic [1:0]  slot_i,
    input  logic        rewind_on_i,
    input  logic        vsync_i,
    output logic        request_savestate_o,
    output logic        request_loadstate_o,
    output logic [31:0] request_address_o,
    input  logic        request_busy_i,
    output logic        core_sleep_o,
    output logic        busy_o,
    output logic        rewind_active_o,
    output logic        timeout_err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VS, S_SLEEP, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_save_q, is_save_d;
    logic        is_rew_q, is_rew_d;
    logic [31:0] addr_q, addr_d;
    logic        terr_q, terr_d;
    logic        vs_q;
    logic        vs_edge;
    logic        complete;
    logic        cap_taken;
    logic        rew_load_req;
    logic        cap_req;
    logic [31:0] ring_save_addr;
    logic [31:0] ring_load_addr;
    logic [31:0] manual_addr;

    assign vs_edge     = vsync_i & ~vs_q;
    assign manual_addr = SLOT_BASE + {30'b0, slot_i} * SLOT_SIZE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            is_save_q <= 1'b0;
            is_rew_q  <= 1'b0;
            terr_q    <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_save_q <= is_save_d;
            is_rew_q  <= is_rew_d;
            terr_q    <= terr_d;
            vs_q      <= vsync_i;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_save_d = is_save_q;
        is_rew_d  = is_rew_q;
        addr_d    = addr_q;
        terr_d    = terr_q;
        complete  = 1'b0;
        cap_taken = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Manual requests outrank rewind events arriving in the same cycle.
                if (save_i) begin
                    is_save_d = 1'b1;
                    is_rew_d  = 1'b0;
                    addr_d    = manual_addr;
                    state_d   = S_WAIT_VS;
                end else if (load_i) begin
                    is_save_d = 1'b0;
                    is_rew_d  = 1'b0;
                    addr_d    = manual_addr;
                    state_d   = S_WAIT_VS;
                end else if (rew_load_req) begin
                    is_save_d = 1'b0;
                    is_rew_d  = 1'b1;
                    addr_d    = ring_load_addr;
                    state_d   = S_WAIT_VS;
                end else if (cap_req) begin
                    is_save_d = 1'b1;
                    is_rew_d  = 1'b1;
                    addr_d    = ring_save_addr;
                    cap_taken = 1'b1;
                    state_d   = S_WAIT_VS;
                end
                if (state_d == S_WAIT_VS) begin
                    terr_d = 1'b0;
                end
            end
            S_WAIT_VS: begin
                if (vs_edge) begin
                    cnt_d   = 8'd0;
                    state_d = S_SLEEP;
                end
            end
            S_SLEEP: begin
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (request_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!request_busy_i) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_sleep_o        = (state_q == S_SLEEP) || (state_q == S_ISSUE) ||
                                 (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);
    assign busy_o              = (state_q != S_IDLE);
    assign request_savestate_o = (state_q == S_ISSUE) && is_save_q;
    assign request_loadstate_o = (state_q == S_ISSUE) && !is_save_q;
    assign request_address_o   = (state_q == S_ISSUE) ? addr_q : 32'd0;
    assign timeout_err_o       = terr_q;

`ifdef GB_SS_REWIND_EN
    localparam int IW = (REWIND_DEPTH > 1) ? $clog2(REWIND_DEPTH) : 1;
    localparam int VW = $clog2(REWIND_DEPTH + 1);

    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx;
    logic [VW-1:0] valid_q, valid_d;
    logic [7:0]    ivl_q, ivl_d;
    logic          pend_q, pend_d;

    assign rd_idx         = (wr_idx_q == '0) ? IW'(REWIND_DEPTH - 1) : wr_idx_q - 1'b1;
    assign ring_save_addr = REWIND_BASE + 32'(wr_idx_q) * SLOT_SIZE;
    assign ring_load_addr = REWIND_BASE + 32'(rd_idx) * SLOT_SIZE;
    assign rew_load_req   = rewind_on_i && (valid_q != '0) && vs_edge;
    // A pending capture waits while the player is rewinding.
    assign cap_req        = pend_q && !rewind_on_i;

    always_comb begin
        wr_idx_d = wr_idx_q;
        valid_d  = valid_q;
        ivl_d    = ivl_q;
        pend_d   = pend_q;
        if (cap_taken) begin
            pend_d = 1'b0;
        end
        if (vs_edge && !rewind_on_i) begin
            if (ivl_q == 8'(REWIND_INTERVAL - 1)) begin
                ivl_d  = 8'd0;
                pend_d = 1'b1;
            end else begin
                ivl_d = ivl_q + 8'd1;
            end
        end
        if (complete) begin
            if (is_rew_q && is_save_q) begin
                wr_idx_d = (wr_idx_q == IW'(REWIND_DEPTH - 1)) ? '0 : wr_idx_q + 1'b1;
                if (valid_q != VW'(REWIND_DEPTH)) begin
                    valid_d = valid_q + 1'b1;
                end
            end else if (is_rew_q) begin
                wr_idx_d = rd_idx;
                valid_d  = valid_q - 1'b1;
            end else if (!is_save_q) begin
                valid_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_idx_q <= '0;
            valid_q  <= '0;
            ivl_q    <= 8'd0;
            pend_q   <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            valid_q  <= valid_d;
            ivl_q    <= ivl_d;
            pend_q   <= pend_d;
        end
    end

    assign rewind_active_o = rewind_on_i && (valid_q != '0);
`else
    logic unused_rewind;

    assign ring_save_addr  = 32'd0;
    assign ring_load_addr  = 32'd0;
    assign rew_load_req    = 1'b0;
    assign cap_req         = 1'b0;
    assign rewind_active_o = 1'b0;
    // Rewind inputs and configuration are inert in this build.
    assign unused_rewind   = ^{rewind_on_i, cap_taken, complete, is_rew_q, REWIND_BASE,
                               32'(REWIND_DEPTH), 32'(REWIND_INTERVAL)};
`endif

endmodule
